// File: rtl/can_clk_gen.sv
// CAN time-quantum clock divider: emits a registered divided clock and a one-cycle enable strobe.
// Defining CAN_CLK_GEN_ASSERT_EN compiles in concurrent property checks; logic is identical either way.
module can_clk_gen #(
  parameter int DIVISOR = 200
) (
  input  logic clock_in_i,
  input  logic reset_i,
  input  logic en_i,
  input  logic sync_i,
  output logic clock_out_o,
  output logic clock_pulse_out_o
);

  localparam int CW = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;
  localparam int H  = DIVISOR / 2;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIVISOR - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);

  generate
    if (DIVISOR < 2) begin : g_divisor_check
      $error("can_clk_gen: DIVISOR must be at least 2");
    end
  endgenerate

  logic [CW-1:0] cnt_reg;

  // Output goes high on wrap (cnt 0..H-1 high), low once cnt passes H-1.
  always_ff @(posedge clock_in_i or negedge reset_i) begin
    if (!reset_i) begin
      cnt_reg           <= '0;
      clock_out_o       <= 1'b0;
      clock_pulse_out_o <= 1'b0;
    end else if (sync_i) begin
      cnt_reg           <= '0;
      clock_out_o       <= 1'b0;
      clock_pulse_out_o <= 1'b0;
    end else if (!en_i) begin
      clock_pulse_out_o <= 1'b0;
    end else if (cnt_reg == CNT_LAST) begin
      cnt_reg           <= '0;
      clock_out_o       <= 1'b1;
      clock_pulse_out_o <= 1'b1;
    end else if (cnt_reg == CNT_HALF) begin
      cnt_reg           <= cnt_reg + CW'(1);
      clock_out_o       <= 1'b0;
      clock_pulse_out_o <= 1'b0;
    end else begin
      cnt_reg           <= cnt_reg + CW'(1);
      clock_pulse_out_o <= 1'b0;
    end
  end

`ifdef CAN_CLK_GEN_ASSERT_EN
  a_cnt_range: assert property (@(posedge clock_in_i) disable iff (!reset_i)
    cnt_reg <= CNT_LAST);
  a_pulse_on_rise: assert property (@(posedge clock_in_i) disable iff (!reset_i)
    clock_pulse_out_o |-> (clock_out_o && !$past(clock_out_o)));
  a_pulse_needs_en: assert property (@(posedge clock_in_i) disable iff (!reset_i)
    clock_pulse_out_o |-> $past(en_i));
  a_pulse_single: assert property (@(posedge clock_in_i) disable iff (!reset_i)
    clock_pulse_out_o |=> !clock_pulse_out_o);
`endif

endmodule

// File: tb/tb_can_clk_gen.sv
// Directed bench for can_clk_gen at DIVISOR 200, 5 and 2; expectations come from the
// waveform formula over enabled cycles since restart.
module tb_can_clk_gen;

  logic clk = 1'b0;
  logic reset_n;
  logic en200, en5, en2;
  logic sync200, sync5, sync2;
  logic o200, p200, o5, p5, o2, p2;

  int total  = 0;
  int passed = 0;
  int e200, e5, e2;

  always #5 clk = ~clk;

  can_clk_gen #(.DIVISOR(200)) u_d200 (
    .clock_in_i(clk), .reset_i(reset_n), .en_i(en200), .sync_i(sync200),
    .clock_out_o(o200), .clock_pulse_out_o(p200));
  can_clk_gen #(.DIVISOR(5)) u_d5 (
    .clock_in_i(clk), .reset_i(reset_n), .en_i(en5), .sync_i(sync5),
    .clock_out_o(o5), .clock_pulse_out_o(p5));
  can_clk_gen #(.DIVISOR(2)) u_d2 (
    .clock_in_i(clk), .reset_i(reset_n), .en_i(en2), .sync_i(sync2),
    .clock_out_o(o2), .clock_pulse_out_o(p2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic out_of(input int d);
    case (d)
      200:     return o200;
      5:       return o5;
      default: return o2;
    endcase
  endfunction

  function automatic logic pulse_of(input int d);
    case (d)
      200:     return p200;
      5:       return p5;
      default: return p2;
    endcase
  endfunction

  // Runs n enabled cycles on one instance (others held) and checks both outputs each cycle.
  task automatic run_check(input int d, input int e_start, input int n, output int e_end);
    int e;
    logic exp_out, exp_pulse;
    e = e_start;
    en200 = (d == 200);
    en5   = (d == 5);
    en2   = (d == 2);
    for (int i = 0; i < n; i++) begin
      tick();
      e++;
      exp_out   = (e >= d) && ((e % d) < (d / 2));
      exp_pulse = (e >= d) && ((e % d) == 0);
      if (out_of(d) !== exp_out)
        $display("FAIL clk_out d=%0d e=%0d: got %b expected %b", d, e, out_of(d), exp_out);
      else
        passed++;
      total++;
      if (pulse_of(d) !== exp_pulse)
        $display("FAIL pulse d=%0d e=%0d: got %b expected %b", d, e, pulse_of(d), exp_pulse);
      else
        passed++;
      total++;
    end
    e_end = e;
    $display("run d=%0d enabled cycles %0d..%0d checked", d, e_start, e);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    en200 = 1'b0; en5 = 1'b0; en2 = 1'b0;
    sync200 = 1'b0; sync5 = 1'b0; sync2 = 1'b0;
    tick();
    tick();
    if ({o200, p200, o5, p5, o2, p2} !== 6'b0)
      $display("FAIL reset_outputs: got %b expected 000000", {o200, p200, o5, p5, o2, p2});
    else
      passed++;
    total++;
    reset_n = 1'b1;
    $display("reset: outputs %b", {o200, p200, o5, p5, o2, p2});
  endtask

  task automatic test_first_period();
    run_check(200, 0, 600, e200);
  endtask

  task automatic test_en_stall();
    run_check(200, e200, 50, e200);
    en200 = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (o200 !== 1'b1 || p200 !== 1'b0)
        $display("FAIL stall_hold cyc=%0d: got out=%b pulse=%b expected out=1 pulse=0", i, o200, p200);
      else
        passed++;
      total++;
    end
    $display("stall: 7 disabled cycles in high phase");
    run_check(200, e200, 349, e200);
    // Disable on the edge that would fire the pulse: it must be deferred.
    en200 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (o200 !== 1'b0 || p200 !== 1'b0)
        $display("FAIL pulse_suppress cyc=%0d: got out=%b pulse=%b expected out=0 pulse=0", i, o200, p200);
      else
        passed++;
      total++;
    end
    $display("suppress: pulse held off for 3 disabled cycles");
    run_check(200, e200, 151, e200);
  endtask

  task automatic test_sync();
    sync200 = 1'b1;
    en200   = 1'b1;
    tick();
    sync200 = 1'b0;
    if (o200 !== 1'b0 || p200 !== 1'b0)
      $display("FAIL sync_low_phase: got out=%b pulse=%b expected out=0 pulse=0", o200, p200);
    else
      passed++;
    total++;
    $display("sync at cnt=150 applied");
    run_check(200, 0, 450, e200);
    en200   = 1'b0;
    sync200 = 1'b1;
    tick();
    sync200 = 1'b0;
    if (o200 !== 1'b0 || p200 !== 1'b0)
      $display("FAIL sync_high_phase_en0: got out=%b pulse=%b expected out=0 pulse=0", o200, p200);
    else
      passed++;
    total++;
    $display("sync at cnt=50 with en low applied");
    run_check(200, 0, 200, e200);
  endtask

  task automatic test_async_reset();
    // Entered just after a pulse edge: out=1, pulse=1.
    #2;
    reset_n = 1'b0;
    #1;
    if (o200 !== 1'b0 || p200 !== 1'b0)
      $display("FAIL async_reset: got out=%b pulse=%b expected out=0 pulse=0", o200, p200);
    else
      passed++;
    total++;
    tick();
    tick();
    if (o200 !== 1'b0 || p200 !== 1'b0)
      $display("FAIL reset_held: got out=%b pulse=%b expected out=0 pulse=0", o200, p200);
    else
      passed++;
    total++;
    reset_n = 1'b1;
    $display("async reset: outputs dropped mid-cycle");
    run_check(200, 0, 400, e200);
  endtask

  task automatic test_div5();
    run_check(5, 0, 25, e5);
  endtask

  task automatic test_div2();
    run_check(2, 0, 10, e2);
  endtask

  initial begin
    test_reset();
    test_first_period();
    test_en_stall();
    test_sync();
    test_async_reset();
    test_div5();
    test_div2();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
